ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter that shares the single-port data RAM of `riscv32s` between the core load/store port and a host port. The host port is the FPGA loader/dumper that writes JPEG source pixels in and reads encoded output back. The arbiter owns the RAM enable, write-enable, address and write-data pins. It gives the core priority and guarantees host progress through a starvation counter. It also screens out-of-range addresses.

## Interface
Parameters:
- `ADDRWIDTH`, 10: word-address width of both requester ports.
- `DATAWIDTH`, 32: data width.
- `RAMDEPTH`, 1024: number of implemented RAM words; valid addresses are 0..RAMDEPTH-1.
- `MAXWAIT`, 4: consecutive lost host cycles before host priority is forced (≥1).

Ports:
- `clock`  in  1: sole clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `core_req`, `host_req`  in  1: access request; must be held with its request fields stable until granted.
- `core_we`, `host_we`  in  1: 1 = write, 0 = read.
- `core_addr`, `host_addr`  in  ADDRWIDTH: word address.
- `core_wdata`, `host_wdata`  in  DATAWIDTH: write data.
- `core_gnt`, `host_gnt`  out  1: combinational; request accepted this cycle.
- `core_rvalid`, `host_rvalid`  out  1: registered; read data valid one cycle after a read grant.
- `core_rdata`, `host_rdata`  out  DATAWIDTH: read data, meaningful only while the matching rvalid is high.
- `ram_en`, `ram_we`  out  1: RAM strobe and write enable.
- `ram_addr`  out  ADDRWIDTH: RAM address.
- `ram_wdata`  out  DATAWIDTH: RAM write data.
- `ram_rdata`  in  DATAWIDTH: RAM read data, valid the cycle after `ram_en && !ram_we`.
- `addr_err`  out  1: sticky; set on any granted out-of-range access.

## Operation
- FSM with two states:
  - PRIO_CORE (reset state).
  - PRIO_HOST.
- Grant rules (at most one grant per cycle):
  - Only one requester active: that requester is granted.
  - Both active in PRIO_CORE: core is granted.
  - Both active in PRIO_HOST: host is granted.
  - Neither active: no grant, `ram_en`=0.
- Wait counter (width clog2(MAXWAIT+1)):
  - Increments each cycle `host_req && !host_gnt`.
  - Clears on any host grant or whenever `host_req`=0.
- Transitions:
  - PRIO_CORE→PRIO_HOST at the edge where the counter would reach MAXWAIT.
  - PRIO_HOST→PRIO_CORE at the edge after the host's next grant.
  - MAXWAIT=1: host wins the second conflicting cycle.
- RAM mux: `ram_addr`, `ram_we` and `ram_wdata` come from the granted requester.
  - `ram_en` = grant && in-range.
  - When there is no grant, outputs hold 0.
- Out-of-range (addr ≥ RAMDEPTH) access:
  - Still granted; `ram_en`=0 and `addr_err` sets.
  - A read still returns rvalid, with rdata forced to 0.
  - A write is dropped.
- Read return:
  - A one-bit source tag and an in-range flag are registered with each read grant.
  - Next cycle, `ram_rdata` (or 0 if out of range) is routed to the tagged port's rdata with its rvalid=1.
  - The other port's rdata is 0.
- Writes complete at the grant edge and produce no rvalid.
- Same-cycle conflict on the same address:
  - Only the winner accesses; the loser retries later.
  - A loser read issued after a winner write sees the new data.

## Timing
- Reset values: state PRIO_CORE, counter 0, both rvalid 0, both rdata 0, `addr_err` 0. Gnt and ram_* outputs are 0 while all req are low.
- Grant latency: 0 cycles (combinational from req and state).
- Read latency: data and rvalid one cycle after the grant cycle.
- Throughput: back-to-back grants to either port every cycle, including read-after-read pipelining.
- Reset asserted mid-operation:
  - An outstanding read is discarded, with no rvalid the following cycle.
  - The FSM and counter return to reset values at that edge.
  - `addr_err` clears.
- While `reset`=1, all gnt=0 and `ram_en`=0 regardless of req.

## Test plan
- Core reads addr 5 alone (RAM holds 42) → `core_gnt`=1 same cycle; next cycle `core_rvalid`=1, `core_rdata`=42; `host_rvalid`=0.
- Host writes 0x1234 to addr 7, then core reads addr 7 next cycle → write occurs at the host-grant edge; core read returns 0x1234.
- Core and host both request continuously with MAXWAIT=4 → core granted 4 cycles, host granted on the 5th, core on the 6th; pattern repeats with period 5.
- Host read at addr 1024 with RAMDEPTH=1024 → `host_gnt`=1, `ram_en`=0, next cycle `host_rvalid`=1 and `host_rdata`=0; `addr_err` stays 1 until reset.
- Alternating core read / host read every cycle, no conflict → each rvalid arrives on the correct port exactly one cycle after its grant, with matching data.
- Core read granted, then `reset` high for 1 cycle → no rvalid afterwards; state returns to PRIO_CORE with counter 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: core-priority arbiter for the shared data RAM with host starvation guard and range screening
module ram_arbiter #(
    parameter int ADDRWIDTH = 10,
    parameter int DATAWIDTH = 32,
    parameter int RAMDEPTH  = 1024,
    parameter int MAXWAIT   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 core_req,
    input  logic                 core_we,
    input  logic [ADDRWIDTH-1:0] core_addr,
    input  logic [DATAWIDTH-1:0] core_wdata,
    output logic                 core_gnt,
    output logic                 core_rvalid,
    output logic [DATAWIDTH-1:0] core_rdata,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDRWIDTH-1:0] host_addr,
    input  logic [DATAWIDTH-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [DATAWIDTH-1:0] host_rdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_wdata,
    input  logic [DATAWIDTH-1:0] ram_rdata,
    output logic                 addr_err
);
    localparam int CW = $clog2(MAXWAIT + 1);
    typedef enum logic {PRIO_CORE, PRIO_HOST} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic gnt, in_range, rd_pend, rd_tag, rd_inr;
    always_comb begin
        core_gnt = !reset && core_req && (!host_req || state == PRIO_CORE);
        host_gnt = !reset && host_req && !core_gnt;
        gnt = core_gnt || host_gnt;
        ram_addr = core_gnt ? core_addr : host_gnt ? host_addr : '0;
        ram_we = core_gnt ? core_we : host_gnt && host_we;
        ram_wdata = core_gnt ? core_wdata : host_gnt ? host_wdata : '0;
        in_range = 32'(ram_addr) < RAMDEPTH;
        ram_en = gnt && in_range;
        cnt_nx = (host_req && !host_gnt) ? cnt + 1'b1 : '0;
        state_nx = state == PRIO_CORE ? (cnt_nx == CW'(MAXWAIT) ? PRIO_HOST : PRIO_CORE)
                                      : (host_gnt ? PRIO_CORE : PRIO_HOST);
        // reset suppresses a read return that is still in flight
        core_rvalid = !reset && rd_pend && !rd_tag;
        host_rvalid = !reset && rd_pend && rd_tag;
        core_rdata = core_rvalid && rd_inr ? ram_rdata : '0;
        host_rdata = host_rvalid && rd_inr ? ram_rdata : '0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= PRIO_CORE;
            cnt <= '0;
            rd_pend <= 1'b0;
            rd_tag <= 1'b0;
            rd_inr <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            rd_pend <= gnt && !ram_we;
            rd_tag <= host_gnt;
            rd_inr <= in_range;
            if (gnt && !in_range) addr_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with queued expected read data checked by an rvalid monitor
module tb_ram_arbiter;
    logic clock = 0, reset = 1;
    logic core_req = 0, core_we = 0, host_req = 0, host_we = 0;
    logic [10:0] core_addr = 0, host_addr = 0, ram_addr;
    logic [31:0] core_wdata = 0, host_wdata = 0, core_rdata, host_rdata, ram_wdata, ram_rdata;
    logic core_gnt, host_gnt, core_rvalid, host_rvalid, ram_en, ram_we, addr_err;
    logic [31:0] mem [1024];
    logic [31:0] core_q[$], host_q[$];
    int checks = 0, errors = 0;

    ram_arbiter #(.ADDRWIDTH(11), .DATAWIDTH(32), .RAMDEPTH(1024), .MAXWAIT(4)) dut (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (ram_en) begin
            if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
            else ram_rdata <= mem[ram_addr[9:0]];
        end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clock) begin
        if (core_rvalid) begin
            if (core_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL core_rvalid: got unexpected rvalid expected none at %0t", $time);
            end else chk("core_rdata", core_rdata, core_q.pop_front());
            chk("host_rdata_idle", host_rdata, 0);
        end
        if (host_rvalid) begin
            if (host_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL host_rvalid: got unexpected rvalid expected none at %0t", $time);
            end else chk("host_rdata", host_rdata, host_q.pop_front());
            chk("core_rdata_idle", core_rdata, 0);
        end
    end

    // eg: expected grant 0 none, 1 core, 2 host; ed: expected read data of the granted read
    task automatic step(input logic rs, input logic cr, input logic cw, input logic [10:0] ca,
                        input logic [31:0] cd, input logic hr, input logic hw, input logic [10:0] ha,
                        input logic [31:0] hd, input int eg, input logic een, input logic [31:0] ed);
        @(posedge clock);
        #1;
        reset = rs;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        @(negedge clock);
        chk("core_gnt", core_gnt, eg == 1);
        chk("host_gnt", host_gnt, eg == 2);
        chk("ram_en", ram_en, een);
        if (eg == 1 && !cw) core_q.push_back(ed);
        if (eg == 2 && !hw) host_q.push_back(ed);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + i;
        mem[5] = 42;
        ram_rdata = 0;
        // requests are ignored while reset is high
        step(1, 1, 0, 5, 0, 1, 0, 6, 0, 0, 0, 0);
        step(1, 1, 0, 5, 0, 1, 0, 6, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("addr_err_reset", addr_err, 0);
        chk("core_rvalid_reset", core_rvalid, 0);
        chk("host_rvalid_reset", host_rvalid, 0);
        chk("ram_addr_idle", ram_addr, 0);
        // lone core read of addr 5
        step(0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 1, 42);
        // host write then core read of the same word
        step(0, 0, 0, 0, 0, 1, 1, 7, 32'h1234, 2, 1, 0);
        chk("ram_we_host", ram_we, 1);
        chk("ram_wdata_host", ram_wdata, 32'h1234);
        step(0, 1, 0, 7, 0, 0, 0, 0, 0, 1, 1, 32'h1234);
        // continuous conflict: host wins every fifth cycle
        for (int k = 0; k < 10; k++)
            step(0, 1, 0, 5, 0, 1, 0, 6, 0, (k % 5 == 4) ? 2 : 1, 1, (k % 5 == 4) ? 32'h106 : 42);
        // out-of-range host read
        step(0, 0, 0, 0, 0, 1, 0, 1024, 0, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("addr_err_set", addr_err, 1);
        // alternating reads without conflict
        for (int k = 0; k < 6; k++)
            if (k % 2 == 0) step(0, 1, 0, 3, 0, 0, 0, 0, 0, 1, 1, 32'h103);
            else step(0, 0, 0, 0, 0, 1, 0, 6, 0, 2, 1, 32'h106);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("addr_err_sticky", addr_err, 1);
        // build up host wait, leave a read outstanding, then reset
        step(0, 1, 0, 5, 0, 1, 0, 6, 0, 1, 1, 42);
        step(0, 1, 0, 5, 0, 1, 0, 6, 0, 1, 1, 42);
        @(posedge clock);
        #1;
        reset = 0;
        core_req = 1; core_addr = 5; host_req = 1; host_addr = 6;
        @(negedge clock);
        chk("core_gnt_pre_reset", core_gnt, 1);
        step(1, 1, 0, 5, 0, 1, 0, 6, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("addr_err_cleared", addr_err, 0);
        for (int k = 0; k < 5; k++)
            step(0, 1, 0, 5, 0, 1, 0, 6, 0, (k == 4) ? 2 : 1, 1, (k == 4) ? 32'h106 : 42);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("core_q_drained", core_q.size(), 0);
        chk("host_q_drained", host_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
